mips_controller: RTL and testbench

- Multicycle control unit for the 8-bit mini-MIPS datapath. It sits directly upstream of the ALU and drives its 3-bit alucont, plus every datapath mux select and write strobe.
- Moore FSM sequences fetch (4 byte cycles), decode, execute, memory and writeback for lb, sb, R-type, beq, j and addi.
- Branch resolution uses the ALU zero flag.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/mips_controller_alu_decoder.sv | 30 +++
 rtl/mips_controller.sv | 139 +++++++++++++
 tb/tb_mips_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle mini-MIPS control unit: states, opcodes,
// funct codes, ALU control words and the FSM-to-ALU-decoder aluop.
package mips_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH1  = 4'd0;
  localparam state_t S_FETCH2  = 4'd1;
  localparam state_t S_FETCH3  = 4'd2;
  localparam state_t S_FETCH4  = 4'd3;
  localparam state_t S_DECODE  = 4'd4;
  localparam state_t S_MEMADR  = 4'd5;
  localparam state_t S_LBRD    = 4'd6;
  localparam state_t S_LBWR    = 4'd7;
  localparam state_t S_SBWR    = 4'd8;
  localparam state_t S_RTYPEEX = 4'd9;
  localparam state_t S_RTYPEWR = 4'd10;
  localparam state_t S_BEQEX   = 4'd11;
  localparam state_t S_JEX     = 4'd12;
  localparam state_t S_ADDIEX  = 4'd13;
  localparam state_t S_ADDIWR  = 4'd14;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef logic [1:0] aluop_t;
  localparam aluop_t ALUOP_ADD   = 2'b00;
  localparam aluop_t ALUOP_SUB   = 2'b01;
  localparam aluop_t ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_controller_alu_decoder.sv
// Maps the FSM's aluop plus the instruction funct field to the 3-bit ALU control.
module alu_decoder
  import mips_pkg::*;
#(
  parameter int FNW = 6
) (
  input  logic [1:0]     aluop,
  input  logic [FNW-1:0] funct,
  output logic [2:0]     alucont
);

  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucont = ALU_ADD;
          FN_SUB:  alucont = ALU_SUB;
          FN_AND:  alucont = ALU_AND;
          FN_OR:   alucont = ALU_OR;
          FN_SLT:  alucont = ALU_SLT;
          default: alucont = ALU_ADD;
        endcase
      end
      default: alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Moore control FSM for the 8-bit multicycle mini-MIPS: byte-wise fetch, decode,
// and per-instruction execute/memory/writeback sequencing.
module mips_controller
  import mips_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  output logic           memread,
  output logic           memwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic           iord,
  output logic [3:0]     irwrite,
  output logic           memtoreg,
  output logic           regdst,
  output logic           regwrite,
  output logic           pcen,
  output logic [1:0]     pcsource,
  output logic [2:0]     alucont,
  output logic [3:0]     state
);

  state_t state_q, state_d;
  logic   memwrite_raw, regwrite_raw, pcwrite, pcwritecond;
  logic [3:0] irwrite_raw;
  aluop_t aluop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH1;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: state_d = S_FETCH4;
      S_FETCH4: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH1;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LB) ? S_LBRD : S_SBWR;
      S_LBRD:    state_d = S_LBWR;
      S_RTYPEEX: state_d = S_RTYPEWR;
      S_ADDIEX:  state_d = S_ADDIWR;
      default:   state_d = S_FETCH1;
    endcase
  end

  always_comb begin
    memread      = 1'b0;
    memwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    iord         = 1'b0;
    irwrite_raw  = 4'b0000;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    regwrite_raw = 1'b0;
    pcwrite      = 1'b0;
    pcwritecond  = 1'b0;
    pcsource     = 2'b00;
    aluop        = ALUOP_ADD;
    case (state_q)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        memread     = 1'b1;
        irwrite_raw = 4'b0001 << state_q[1:0];
        alusrcb     = 2'b01;
        pcwrite     = 1'b1;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_LBWR: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      S_SBWR: begin
        memwrite_raw = 1'b1;
        iord         = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
      end
      S_BEQEX: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      S_JEX: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      S_ADDIWR: regwrite_raw = 1'b1;
      default: ;
    endcase
  end

  // Architectural strobes are held off while reset is low, even though the
  // state already reads FETCH1.
  assign memwrite = reset & memwrite_raw;
  assign regwrite = reset & regwrite_raw;
  assign pcen     = reset & (pcwrite | (pcwritecond & zero));
  assign irwrite  = reset ? irwrite_raw : 4'b0000;
  assign state    = state_q;

  alu_decoder #(.FNW(FNW)) u_alu_decoder (
    .aluop   (aluop),
    .funct   (funct),
    .alucont (alucont)
  );

endmodule

// File: tb/tb_mips_controller.sv
// Table-driven bench for mips_controller: per-cycle vectors of inputs and the
// expected state and output word, plus reset and mid-instruction reset sequences.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite, state;
  logic [2:0] alucont;
  logic [18:0] act_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  st;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  mips_controller #(.OPW(6), .FNW(6)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .pcen(pcen), .pcsource(pcsource), .alucont(alucont),
    .state(state)
  );

  assign act_o = {memread, memwrite, alusrca, alusrcb, iord, irwrite,
                  memtoreg, regdst, regwrite, pcen, pcsource, alucont};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [18:0] ow(
    input logic mr, input logic mw, input logic asa, input logic [1:0] asb,
    input logic io, input logic [3:0] irw, input logic mtr, input logic rd,
    input logic rw, input logic pc, input logic [1:0] pcs, input logic [2:0] ac);
    return {mr, mw, asa, asb, io, irw, mtr, rd, rw, pc, pcs, ac};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic [3:0] st, input logic [18:0] e);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.st = st; v.exp = e;
    vecs.push_back(v);
  endtask

  // Fetch uses a deliberately wrong op/funct so only DECODE's sample matters.
  task automatic add_fetch(input logic [5:0] o);
    add(~o, 6'h15, 1'b0, 4'd0, ow(1,0,0,2'b01,0,4'b0001,0,0,0,1,2'b00,3'b010));
    add(~o, 6'h2a, 1'b1, 4'd1, ow(1,0,0,2'b01,0,4'b0010,0,0,0,1,2'b00,3'b010));
    add(~o, 6'h07, 1'b0, 4'd2, ow(1,0,0,2'b01,0,4'b0100,0,0,0,1,2'b00,3'b010));
    add(~o, 6'h3f, 1'b1, 4'd3, ow(1,0,0,2'b01,0,4'b1000,0,0,0,1,2'b00,3'b010));
    add(o,  6'h00, 1'b1, 4'd4, ow(0,0,0,2'b11,0,4'b0000,0,0,0,0,2'b00,3'b010));
  endtask

  task automatic add_rtype(input logic [5:0] f, input logic [2:0] ac);
    add_fetch(6'b000000);
    add(6'b000000, f, 1'b1, 4'd9, ow(0,0,1,2'b00,0,4'b0000,0,0,0,0,2'b00,ac));
    add(6'b111111, 6'h00, 1'b1, 4'd10, ow(0,0,0,2'b00,0,4'b0000,0,1,1,0,2'b00,3'b010));
  endtask

  task automatic step_to(input logic [3:0] tgt, input int budget);
    int n = 0;
    while (state !== tgt && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("step_to_state", int'(tgt), {28'd0, state}, {28'd0, tgt});
  endtask

  initial begin
    // R-type: slt, unknown funct, then the remaining functs
    add_rtype(6'b101010, 3'b111);
    add_rtype(6'b000111, 3'b010);
    add_rtype(6'b100000, 3'b010);
    add_rtype(6'b100010, 3'b110);
    add_rtype(6'b100100, 3'b000);
    add_rtype(6'b100101, 3'b001);
    // beq taken, then not taken
    add_fetch(6'b000100);
    add(6'b000100, 6'h00, 1'b1, 4'd11, ow(0,0,1,2'b00,0,4'b0000,0,0,0,1,2'b01,3'b110));
    add_fetch(6'b000100);
    add(6'b000100, 6'h00, 1'b0, 4'd11, ow(0,0,1,2'b00,0,4'b0000,0,0,0,0,2'b01,3'b110));
    // lb
    add_fetch(6'b100000);
    add(6'b100000, 6'h00, 1'b1, 4'd5, ow(0,0,1,2'b10,0,4'b0000,0,0,0,0,2'b00,3'b010));
    add(6'b101000, 6'h00, 1'b1, 4'd6, ow(1,0,0,2'b00,1,4'b0000,0,0,0,0,2'b00,3'b010));
    add(6'b000000, 6'h00, 1'b1, 4'd7, ow(0,0,0,2'b00,0,4'b0000,1,0,1,0,2'b00,3'b010));
    // sb
    add_fetch(6'b101000);
    add(6'b101000, 6'h00, 1'b0, 4'd5, ow(0,0,1,2'b10,0,4'b0000,0,0,0,0,2'b00,3'b010));
    add(6'b100000, 6'h00, 1'b1, 4'd8, ow(0,1,0,2'b00,1,4'b0000,0,0,0,0,2'b00,3'b010));
    // illegal op falls straight back to fetch
    add_fetch(6'b111111);
    // j
    add_fetch(6'b000010);
    add(6'b000100, 6'h00, 1'b0, 4'd12, ow(0,0,0,2'b00,0,4'b0000,0,0,0,1,2'b10,3'b010));
    // addi
    add_fetch(6'b001000);
    add(6'b001000, 6'h00, 1'b1, 4'd13, ow(0,0,1,2'b10,0,4'b0000,0,0,0,0,2'b00,3'b010));
    add(6'b000000, 6'h00, 1'b1, 4'd14, ow(0,0,0,2'b00,0,4'b0000,0,0,1,0,2'b00,3'b010));
    add(6'b000000, 6'h00, 1'b0, 4'd0,  ow(1,0,0,2'b01,0,4'b0001,0,0,0,1,2'b00,3'b010));

    // reset held low for 3 cycles with arbitrary inputs
    reset = 1'b0;
    zero  = 1'b1;
    op    = 6'($urandom_range(0, 63));
    funct = 6'($urandom_range(0, 63));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_state", i, {28'd0, state}, 32'd0);
      chk("rst_strobes", i, {28'd0, pcen, regwrite, memwrite, 1'b0}, 32'd0);
      chk("rst_irwrite", i, {28'd0, irwrite}, 32'd0);
    end
    #1 reset = 1'b1;
    #1;
    chk("rel_fetch", 0, {26'd0, memread, irwrite, pcen}, {26'd0, 1'b1, 4'b0001, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      op    = vecs[i].op;
      funct = vecs[i].funct;
      zero  = vecs[i].zero;
      #2;
      chk("vec_state", i, {28'd0, state}, {28'd0, vecs[i].st});
      chk("vec_outs", i, {13'd0, act_o}, {13'd0, vecs[i].exp});
      @(posedge clk); #1;
    end

    // asynchronous reset in the middle of lb
    op = 6'b100000;
    zero = 1'b0;
    step_to(4'd6, 20);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_state", 0, {28'd0, state}, 32'd0);
    chk("mid_rst_strobes", 0, {29'd0, pcen, regwrite, memwrite}, 32'd0);
    chk("mid_rst_irwrite", 0, {28'd0, irwrite}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_hold", 0, {28'd0, state}, 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("post_rst_fetch1", 0, {26'd0, memread, irwrite, pcen}, {26'd0, 1'b1, 4'b0001, 1'b1});
    @(posedge clk); #1;
    chk("post_rst_state", 0, {28'd0, state}, 32'd1);
    chk("post_rst_fetch2", 0, {26'd0, memread, irwrite, pcen}, {26'd0, 1'b1, 4'b0010, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
